// File: rtl/ekf_stage_sched.sv
// rtl/ekf_stage_sched.sv - EKF-SLAM stage sequencer: command FIFO, one-at-a-time issue, landmark count
// Optional WAIT timeout via `define STAGE_TIMEOUT_EN.
module ekf_stage_sched #(
   parameter int RSA_DW      = 32,
   parameter int RSA_AW      = 17,
   parameter int ROW_LEN     = 10,
   parameter int FIFO_DEPTH  = 4,
   parameter int VAL_CYC     = 2,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic               clk_i,
   input  logic               sys_rst_i,
   input  logic               cmd_val_i,
   output logic               cmd_rdy_o,
   input  logic [2:0]         cmd_stage_i,
   input  logic [ROW_LEN-1:0] cmd_lk_i,
   input  logic [RSA_DW-1:0]  cmd_vlr_i,
   input  logic [RSA_AW-1:0]  cmd_alpha_i,
   input  logic [RSA_DW-1:0]  cmd_rk_i,
   input  logic [RSA_AW-1:0]  cmd_phi_i,
   output logic [2:0]         stage_val_o,
   input  logic [2:0]         stage_rdy_i,
   output logic [ROW_LEN-1:0] landmark_num_o,
   output logic [ROW_LEN-1:0] l_k_o,
   output logic [RSA_DW-1:0]  vlr_o,
   output logic [RSA_AW-1:0]  alpha_o,
   output logic [RSA_DW-1:0]  rk_o,
   output logic [RSA_AW-1:0]  phi_o,
   output logic               busy_o,
   output logic               done_o,
   output logic               err_cmd_o
);

   localparam int EW = 3 + ROW_LEN + 2*RSA_DW + 2*RSA_AW;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int VW = $clog2(VAL_CYC + 1);
   localparam logic [VW-1:0] VAL_LAST = VW'(VAL_CYC - 1);
   localparam logic [2:0] ST_NEW = 3'd2;
   localparam logic [2:0] ST_UPD = 3'd3;
   localparam logic [2:0] ST_MAX = 3'd4;

   generate
      if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || VAL_CYC < 1 || TIMEOUT_CYC < 1) begin : g_bad_cfg
         $error("ekf_stage_sched: illegal parameter set");
      end
   endgenerate

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

   logic [EW-1:0]      mem_q [FIFO_DEPTH];
   logic [PW:0]        wr_ptr_q, rd_ptr_q;
   logic [PW:0]        wr_ptr_d, rd_ptr_d;
   logic               fifo_full, fifo_empty, push, pop;

   logic [2:0]         h_stage;
   logic [ROW_LEN-1:0] h_lk;
   logic [RSA_DW-1:0]  h_vlr, h_rk;
   logic [RSA_AW-1:0]  h_alpha, h_phi;
   logic               cmd_bad;

   state_t             state_q;
   logic [VW-1:0]      val_cnt_q;
   logic [2:0]         stage_q, stage_val_q;
   logic [ROW_LEN-1:0] landmark_num_q, l_k_q;
   logic [RSA_DW-1:0]  vlr_q, rk_q;
   logic [RSA_AW-1:0]  alpha_q, phi_q;
   logic               done_q, err_q;

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
   assign pop        = (state_q == S_IDLE) && !fifo_empty;
   // A pop frees a slot this cycle, so a full FIFO may still accept a push.
   assign cmd_rdy_o  = !fifo_full || pop;
   assign push       = cmd_val_i && cmd_rdy_o;
   assign wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
   assign rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q[PW-1:0]] <= {cmd_stage_i, cmd_lk_i, cmd_vlr_i, cmd_alpha_i, cmd_rk_i, cmd_phi_i};
      end
   end

   always_ff @(posedge clk_i) begin
      if (sys_rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   assign {h_stage, h_lk, h_vlr, h_alpha, h_rk, h_phi} = mem_q[rd_ptr_q[PW-1:0]];

   always_comb begin
      cmd_bad = 1'b0;
      if (h_stage == 3'd0 || h_stage > ST_MAX) cmd_bad = 1'b1;
      if (h_stage == ST_NEW && (&landmark_num_q)) cmd_bad = 1'b1;
      if (h_stage == ST_UPD && h_lk >= landmark_num_q) cmd_bad = 1'b1;
   end

`ifdef STAGE_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
   logic [TW-1:0] tmo_q;
`endif

   always_ff @(posedge clk_i) begin
      if (sys_rst_i) begin
         state_q        <= S_IDLE;
         val_cnt_q      <= '0;
         stage_q        <= '0;
         stage_val_q    <= '0;
         landmark_num_q <= '0;
         l_k_q          <= '0;
         vlr_q          <= '0;
         alpha_q        <= '0;
         rk_q           <= '0;
         phi_q          <= '0;
         done_q         <= 1'b0;
         err_q          <= 1'b0;
`ifdef STAGE_TIMEOUT_EN
         tmo_q          <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (!fifo_empty) begin
                  if (cmd_bad) begin
                     err_q <= 1'b1;
                  end else begin
                     stage_q     <= h_stage;
                     stage_val_q <= h_stage;
                     l_k_q       <= h_lk;
                     vlr_q       <= h_vlr;
                     alpha_q     <= h_alpha;
                     rk_q        <= h_rk;
                     phi_q       <= h_phi;
                     val_cnt_q   <= '0;
                     state_q     <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               // stage_rdy is deliberately not looked at here; the top must hold it.
               if (val_cnt_q == VAL_LAST) begin
                  stage_val_q <= '0;
                  state_q     <= S_WAIT;
`ifdef STAGE_TIMEOUT_EN
                  tmo_q       <= '0;
`endif
               end else begin
                  val_cnt_q <= val_cnt_q + 1'b1;
               end
            end
            S_WAIT: begin
               if (stage_rdy_i == stage_q) begin
                  done_q  <= 1'b1;
                  state_q <= S_IDLE;
                  if (stage_q == ST_NEW) landmark_num_q <= landmark_num_q + 1'b1;
               end
`ifdef STAGE_TIMEOUT_EN
               else if (tmo_q == TMO_LAST) begin
                  err_q   <= 1'b1;
                  state_q <= S_IDLE;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
`endif
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign stage_val_o    = stage_val_q;
   assign landmark_num_o = landmark_num_q;
   assign l_k_o          = l_k_q;
   assign vlr_o          = vlr_q;
   assign alpha_o        = alpha_q;
   assign rk_o           = rk_q;
   assign phi_o          = phi_q;
   assign busy_o         = (state_q != S_IDLE);
   assign done_o         = done_q;
   assign err_cmd_o      = err_q;

endmodule

// File: tb/tb_ekf_stage_sched.sv
// tb/tb_ekf_stage_sched.sv - directed bench for ekf_stage_sched
// Covers STAGE_TIMEOUT_EN when the macro is defined.
module tb_ekf_stage_sched;

   logic        clk = 1'b0;
   logic        sys_rst;
   logic        cmd_val;
   logic        cmd_rdy;
   logic [2:0]  cmd_stage;
   logic [9:0]  cmd_lk;
   logic [31:0] cmd_vlr;
   logic [16:0] cmd_alpha;
   logic [31:0] cmd_rk;
   logic [16:0] cmd_phi;
   logic [2:0]  stage_val;
   logic [2:0]  stage_rdy;
   logic [9:0]  landmark_num;
   logic [9:0]  l_k;
   logic [31:0] vlr;
   logic [16:0] alpha;
   logic [31:0] rk;
   logic [16:0] phi;
   logic        busy;
   logic        done;
   logic        err_cmd;

   int n_vec = 0;
   int n_err = 0;

   ekf_stage_sched #(
      .RSA_DW(32), .RSA_AW(17), .ROW_LEN(10), .FIFO_DEPTH(4), .VAL_CYC(2), .TIMEOUT_CYC(16)
   ) dut (
      .clk_i(clk), .sys_rst_i(sys_rst),
      .cmd_val_i(cmd_val), .cmd_rdy_o(cmd_rdy),
      .cmd_stage_i(cmd_stage), .cmd_lk_i(cmd_lk), .cmd_vlr_i(cmd_vlr),
      .cmd_alpha_i(cmd_alpha), .cmd_rk_i(cmd_rk), .cmd_phi_i(cmd_phi),
      .stage_val_o(stage_val), .stage_rdy_i(stage_rdy),
      .landmark_num_o(landmark_num), .l_k_o(l_k), .vlr_o(vlr), .alpha_o(alpha),
      .rk_o(rk), .phi_o(phi), .busy_o(busy), .done_o(done), .err_cmd_o(err_cmd)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [2:0] st, input logic [9:0] lk, input logic [31:0] v,
                       input logic [16:0] a, input logic [31:0] r, input logic [16:0] p);
      cmd_val = 1'b1; cmd_stage = st; cmd_lk = lk; cmd_vlr = v; cmd_alpha = a; cmd_rk = r; cmd_phi = p;
      tick();
      cmd_val = 1'b0;
   endtask

   task automatic issue_hold(input logic [2:0] code);
      int n;
      n = 0;
      while (stage_val !== code && n < 30) begin tick(); n++; end
      check("issue", stage_val, code);
      n = 0;
      while (stage_val === code && n < 10) begin tick(); n++; end
      check("val_cyc", n, 2);
      check("wait_busy", busy, 1);
   endtask

   task automatic complete(input logic [2:0] code, input logic [9:0] lm);
      stage_rdy = code;
      tick();
      stage_rdy = 3'd0;
      check("done", done, 1);
      check("idle", busy, 0);
      check("lm", landmark_num, lm);
   endtask

   initial begin
      sys_rst = 1'b1; cmd_val = 1'b0; cmd_stage = '0; cmd_lk = '0; cmd_vlr = '0;
      cmd_alpha = '0; cmd_rk = '0; cmd_phi = '0; stage_rdy = '0;
      tick(); tick();
      sys_rst = 1'b0;
      check("rst_val", stage_val, 0);
      check("rst_busy", busy, 0);
      check("rst_lm", landmark_num, 0);
      check("rst_rdy", cmd_rdy, 1);
      check("rst_done", done, 0);
      check("rst_err", err_cmd, 0);

      // 1: ASSOC, bearing MSB set (bit 16 is the top bit of a 17-bit operand)
      push(3'd4, 10'd0, 32'd0, 17'd0, 32'd0, 17'h10000);
      check("t1_no_early", stage_val, 0);
      tick();
      check("t1_lat", stage_val, 4);
      check("t1_busy", busy, 1);
      check("t1_phi", phi, 17'h10000);
      tick();
      check("t1_hold2", stage_val, 4);
      tick();
      check("t1_end", stage_val, 0);
      stage_rdy = 3'd4;
      tick();
      stage_rdy = 3'd0;
      check("t1_done", done, 1);
      check("t1_idle", busy, 0);
      check("t1_phi_held", phi, 17'h10000);
      tick();
      check("t1_done_pulse", done, 0);

      // 2: two NEWs back-to-back
      push(3'd2, 10'd0, 32'h1234, 17'h5, 32'd0, 17'd0);
      push(3'd2, 10'd0, 32'h1234, 17'h5, 32'd0, 17'd0);
      issue_hold(3'd2);
      check("t2_one_out", stage_val, 0);
      complete(3'd2, 10'd1);
      check("t2_gap", stage_val, 0);
      tick();
      check("t2_second", stage_val, 2);
      issue_hold(3'd2);
      complete(3'd2, 10'd2);

      // 3: UPD range check against landmark_num=2
      push(3'd3, 10'd2, 32'd0, 17'd0, 32'd0, 17'd0);
      tick();
      check("t3_err", err_cmd, 1);
      check("t3_noissue", stage_val, 0);
      check("t3_nobusy", busy, 0);
      tick();
      check("t3_err_pulse", err_cmd, 0);
      push(3'd3, 10'd1, 32'hdeadbeef, 17'h1abcd, 32'h0badf00d, 17'h00123);
      tick();
      check("t3_upd", stage_val, 3);
      check("t3_lk", l_k, 1);
      check("t3_rk", rk, 32'h0badf00d);
      check("t3_alpha", alpha, 17'h1abcd);
      issue_hold(3'd3);
      complete(3'd3, 10'd2);

      // 4: fill the FIFO behind an in-flight PRD
      push(3'd1, 10'd0, 32'd1, 17'd1, 32'd1, 17'd1);
      push(3'd7, 10'd0, 32'd0, 17'd0, 32'd0, 17'd0);
      push(3'd4, 10'd5, 32'd0, 17'd0, 32'd0, 17'd0);
      push(3'd1, 10'd0, 32'd0, 17'd0, 32'd0, 17'd0);
      check("t4_rdy_3buf", cmd_rdy, 1);
      push(3'd4, 10'd0, 32'd0, 17'd0, 32'd0, 17'd0);
      check("t4_rdy_full", cmd_rdy, 0);
      check("t4_busy", busy, 1);
      check("t4_in_wait", stage_val, 0);
      complete(3'd1, 10'd2);
      check("t4_rdy_full_pop", cmd_rdy, 1);
      tick();
      check("t4_bad_err", err_cmd, 1);
      check("t4_bad_noissue", stage_val, 0);
      tick();
      check("t4_next", stage_val, 4);
      stage_rdy = 3'd4;               // early completion, held across ISSUE
      tick();
      check("t4_early_hold", stage_val, 4);
      check("t4_early_nodone", done, 0);
      tick();
      check("t4_early_wait", stage_val, 0);
      check("t4_early_nodone2", done, 0);
      tick();
      stage_rdy = 3'd0;
      check("t4_early_done", done, 1);

      // 5: mismatched completion code ignored
      issue_hold(3'd1);
      stage_rdy = 3'd3;
      tick(); tick(); tick();
      check("t5_ign_done", done, 0);
      check("t5_ign_busy", busy, 1);
      complete(3'd1, 10'd2);

      // 6: reset during WAIT with a queued command
      issue_hold(3'd4);
      push(3'd2, 10'd0, 32'd7, 17'd7, 32'd7, 17'd7);
      sys_rst = 1'b1;
      tick();
      sys_rst = 1'b0;
      check("t6_val", stage_val, 0);
      check("t6_busy", busy, 0);
      check("t6_lm", landmark_num, 0);
      check("t6_rdy", cmd_rdy, 1);
      check("t6_done", done, 0);
      check("t6_err", err_cmd, 0);
      check("t6_ops", {l_k, vlr, phi}, 0);
      tick(); tick(); tick();
      check("t6_no_stale", {busy, stage_val}, 0);

      // saturate landmark_num, then NEW must be dropped
      for (int i = 0; i < 1023; i++) begin
         push(3'd2, 10'd0, 32'd0, 17'd0, 32'd0, 17'd0);
         stage_rdy = 3'd2;
         tick(); tick(); tick(); tick();
         stage_rdy = 3'd0;
      end
      check("sat_lm", landmark_num, 1023);
      push(3'd2, 10'd0, 32'd0, 17'd0, 32'd0, 17'd0);
      tick();
      check("sat_err", err_cmd, 1);
      check("sat_noissue", stage_val, 0);
      check("sat_lm_held", landmark_num, 1023);

`ifdef STAGE_TIMEOUT_EN
      begin
         int n;
         push(3'd1, 10'd0, 32'd0, 17'd0, 32'd0, 17'd0);
         issue_hold(3'd1);
         n = 0;
         while (err_cmd !== 1'b1 && n < 40) begin tick(); n++; end
         check("tmo_cyc", n, 16);
         check("tmo_nodone", done, 0);
         check("tmo_idle", busy, 0);
         check("tmo_lm", landmark_num, 1023);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
